dmem_byte_lane: RTL and testbench
=================================

Name: dmem_byte_lane

Overview:
Data memory for the single-cycle core. Sits directly downstream of the store-data formatter: it consumes the right-justified, zero-extended store word `wd` and the 2-bit store type. It places the active bytes into the correct lanes from the low address bits and performs a byte-masked synchronous write. It returns the full addressed word combinationally for the load path. After reset it runs a sequential clear sweep that zeroes every word before accepting accesses.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words; power of two, ≥ 2.
AW, $clog2(DEPTH_WORDS), word-index width, derived; not overridden.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous active-high reset.
addr  input  32  byte address from ALU; word index = addr[AW+1:2], upper bits ignored (aliasing wrap).
wd  input  32  store data, right-justified (sb: [7:0], sh: [15:0], sw: [31:0]).
storeCtrl  input  2  00 = sb, 01 = sh, 10 = sw, 11 = sw.
memWrite  input  1  write request for this cycle.
rd  output  32  full word at addr (combinational).
busy  output  1  clear sweep in progress; all accesses ignored.
misaligned  output  1  combinational: memWrite & ~busy & illegal alignment.
err_sticky  output  1  registered; set on any suppressed misaligned write, cleared only by rst.

Behaviour:
- Reset (rst=1 at posedge):
  - state ← CLEAR, clr_idx ← 0, err_sticky ← 0.
  - busy=1 while in CLEAR, including the cycle rst is held.
  - Memory contents are not touched while rst is held.
- FSM states: CLEAR, READY.
  - CLEAR: each cycle with rst=0, mem[clr_idx] ← 0 and clr_idx ← clr_idx+1.
  - When clr_idx == DEPTH_WORDS-1 is written, state ← READY on that same edge. The sweep therefore takes exactly DEPTH_WORDS cycles after rst deasserts.
  - READY: terminal until the next rst.
  - Reset mid-sweep restarts at clr_idx=0.
- busy: 1 in CLEAR, 0 in READY.
  - While busy: rd = 0, writes are ignored, misaligned = 0.
- Lane placement (READY, memWrite=1), with a = addr[1:0]:
  - sb: byte lane a ← wd[7:0]; byte enable = 0001 << a.
  - sh: a=00 → lanes 1:0 ← wd[15:0], be=0011. a=10 → lanes 3:2 ← wd[15:0], be=1100. a=01 or 11 → misaligned, no write.
  - sw/11: a=00 → all lanes ← wd, be=1111. a≠00 → misaligned, no write.
- Write timing and masking:
  - The write occurs at the posedge.
  - Lanes with be=0 keep their value.
  - Bits of wd above the store width are ignored.
- Misaligned write:
  - Memory is unchanged.
  - misaligned=1 in that cycle.
  - err_sticky ← 1 at the next posedge.
- Read: rd = mem[addr[AW+1:2]] combinationally; no sign/zero extension (the load formatter does that).
- Same-cycle write and read to the same word: rd shows the pre-write value; the new value is visible after the edge.
- memWrite=0: no state change. storeCtrl is don't-care.
- Address alias: addr and addr + 4*DEPTH_WORDS map to the same word.

Test Plan:
- Reset/clear:
  - Preload mem[5]=0xDEADBEEF via backdoor, pulse rst for 1 cycle.
  - busy must stay 1 for exactly 256 cycles, then drop to 0.
  - rd at addr 0x14 must then read 0x00000000.
  - A memWrite during busy must have no effect.
- Byte lanes:
  - After clear, sb wd=0x123456AB to addr 0x41, then sb wd=0xCD to addr 0x43.
  - Read of 0x40 must give 0xCD00AB00.
- Halfword and word:
  - sw 0x11223344 at 0x80, then sh wd=0xFFFF_BEEF at 0x82.
  - rd at 0x80 must give 0xBEEF3344.
  - sh 0x5566 at 0x80 must then give 0xBEEF5566.
- Misaligned:
  - sh at 0x81 with wd=0xAAAA must leave 0x80 unchanged; misaligned=1 that cycle; err_sticky=1 from the next cycle.
  - sw at 0x82 behaves the same way.
  - err_sticky must stay 1 until rst.
- Read-during-write and alias:
  - sw 0xCAFEF00D at 0x10; rd at 0x10 in the same cycle must show the old value and 0xCAFEF00D after the edge.
  - Read at 0x410 (DEPTH 256) must also return 0xCAFEF00D.
- Reset mid-sweep:
  - Assert rst at sweep cycle 100.
  - busy must remain 1 for a further full 256 cycles after rst deasserts.

Source files
------------

// File: rtl/dmem_byte_lane_if.sv
// Bus bundle between the core's store/load path and dmem_byte_lane.
//   master: drives addr, wd, storeCtrl, memWrite; observes rd, busy,
//           misaligned, err_sticky.
//   slave : the memory side (mirror directions).
interface dmem_byte_lane_if;
  logic [31:0] addr;
  logic [31:0] wd;
  logic [1:0]  storeCtrl;
  logic        memWrite;
  logic [31:0] rd;
  logic        busy;
  logic        misaligned;
  logic        err_sticky;

  modport master (
    output addr, wd, storeCtrl, memWrite,
    input  rd, busy, misaligned, err_sticky
  );

  modport slave (
    input  addr, wd, storeCtrl, memWrite,
    output rd, busy, misaligned, err_sticky
  );
endinterface

// File: rtl/dmem_byte_lane.sv
// Byte-lane data memory for the single-cycle core.
// Takes right-justified store data, steers it into byte lanes from addr[1:0],
// and performs a byte-masked synchronous write. The addressed word is returned
// combinationally. After reset a sweep zeroes every word before accesses are
// accepted.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - dmem_byte_lane_if.slave:
//            addr       byte address, word index = addr[AW+1:2] (upper bits alias)
//            wd         right-justified store data
//            storeCtrl  00 sb, 01 sh, 10/11 sw
//            memWrite   write request
//            rd         addressed word (combinational, 0 while busy)
//            busy       clear sweep in progress
//            misaligned combinational flag for a suppressed illegal write
//            err_sticky set by any misaligned write, cleared only by rst
module dmem_byte_lane #(
  parameter int unsigned DEPTH_WORDS = 256
) (
  input  logic            clk,
  input  logic            rst,
  dmem_byte_lane_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t         state;
  logic [AW-1:0]  clr_idx;
  logic           err_sticky_q;
  logic [31:0]    mem [DEPTH_WORDS];

  logic [AW-1:0]  widx;
  logic [1:0]     a;
  logic [3:0]     be;
  logic [31:0]    lane_data;
  logic           illegal;
  logic           busy_c;
  logic           mis_c;
  logic           wr_en;
  logic           unused_addr_hi;

  assign widx           = bus.addr[AW+1:2];
  assign a              = bus.addr[1:0];
  assign unused_addr_hi = &{1'b0, bus.addr[31:AW+2]};

  assign busy_c = (state == CLEAR);
  assign mis_c  = bus.memWrite & ~busy_c & illegal;
  assign wr_en  = bus.memWrite & ~busy_c & ~illegal;

  // Lane steering: replicate the active bytes across the word, select with be.
  always_comb begin
    be        = 4'b0000;
    lane_data = 32'h0;
    illegal   = 1'b0;
    unique case (bus.storeCtrl)
      2'b00: begin
        be        = 4'b0001 << a;
        lane_data = {4{bus.wd[7:0]}};
      end
      2'b01: begin
        lane_data = {2{bus.wd[15:0]}};
        if (a == 2'b00)      be = 4'b0011;
        else if (a == 2'b10) be = 4'b1100;
        else                 illegal = 1'b1;
      end
      default: begin
        lane_data = bus.wd;
        if (a == 2'b00) be = 4'b1111;
        else            illegal = 1'b1;
      end
    endcase
  end

  // Control FSM: clear sweep after reset, then terminal READY.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= CLEAR;
      clr_idx      <= '0;
      err_sticky_q <= 1'b0;
    end else begin
      if (mis_c) err_sticky_q <= 1'b1;
      unique case (state)
        CLEAR: begin
          clr_idx <= clr_idx + AW'(1);
          if (clr_idx == AW'(DEPTH_WORDS - 1)) state <= READY;
        end
        default: state <= READY;
      endcase
    end
  end

  // Storage: untouched while rst is held; sweep clears, otherwise masked write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        mem[clr_idx] <= 32'h0;
      end else if (wr_en) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) mem[widx][8*b +: 8] <= lane_data[8*b +: 8];
        end
      end
    end
  end

  assign bus.rd         = busy_c ? 32'h0 : mem[widx];
  assign bus.busy       = busy_c;
  assign bus.misaligned = mis_c;
  assign bus.err_sticky = err_sticky_q;

endmodule

// File: tb/tb_dmem_byte_lane.sv
// Directed bench for dmem_byte_lane: clear sweep timing, lane placement,
// misalignment suppression, read-during-write, aliasing and mid-sweep reset.
module tb_dmem_byte_lane;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   n;
  logic exp_sticky;

  dmem_byte_lane_if bus ();

  dmem_byte_lane #(.DEPTH_WORDS(256)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wd;
    logic [1:0]  ctrl;
    logic        we;
    logic [31:0] pre;
    logic        mis;
    logic [31:0] post;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Step cycles until busy drops, stop_at cycles elapse, or the budget runs out.
  // With poke set, a few accesses are attempted mid-sweep.
  task automatic wait_ready(input int stop_at, input bit poke, output int cnt);
    cnt = 0;
    while (bus.busy === 1'b1 && cnt < stop_at && cnt < 1000) begin
      if (poke && cnt == 100) begin
        bus.addr = 32'h14;
        #1;
        check("rd_zero_while_busy", bus.rd, 32'h0);
      end
      if (poke && cnt == 200) begin
        bus.addr = 32'h30; bus.wd = 32'h99999999; bus.storeCtrl = 2'b10; bus.memWrite = 1'b1;
      end
      if (poke && cnt == 201) begin
        bus.addr = 32'h31; bus.storeCtrl = 2'b01; bus.memWrite = 1'b1;
        #1;
        check("mis_zero_while_busy", 32'(bus.misaligned), 32'h0);
      end
      if (poke && cnt == 202) bus.memWrite = 1'b0;
      tick();
      cnt++;
    end
  endtask

  task automatic read_at(input logic [31:0] ad, input string name, input logic [31:0] exp);
    bus.addr = ad;
    bus.memWrite = 1'b0;
    #1;
    check(name, bus.rd, exp);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    bus.addr = 32'h0; bus.wd = 32'h0; bus.storeCtrl = 2'b00; bus.memWrite = 1'b0;
    rst = 1'b1;

    //                addr          wd            ctrl   we    pre           mis   post
    vecs[0]  = '{32'h41,  32'h123456AB, 2'b00, 1'b1, 32'h00000000, 1'b0, 32'h0000AB00};
    vecs[1]  = '{32'h43,  32'h000000CD, 2'b00, 1'b1, 32'h0000AB00, 1'b0, 32'hCD00AB00};
    vecs[2]  = '{32'h80,  32'h11223344, 2'b10, 1'b1, 32'h00000000, 1'b0, 32'h11223344};
    vecs[3]  = '{32'h82,  32'hFFFFBEEF, 2'b01, 1'b1, 32'h11223344, 1'b0, 32'hBEEF3344};
    vecs[4]  = '{32'h80,  32'h00005566, 2'b01, 1'b1, 32'hBEEF3344, 1'b0, 32'hBEEF5566};
    vecs[5]  = '{32'h02,  32'hFFFFFF77, 2'b00, 1'b1, 32'h00000000, 1'b0, 32'h00770000};
    vecs[6]  = '{32'h07,  32'h00000012, 2'b00, 1'b1, 32'h00000000, 1'b0, 32'h12000000};
    vecs[7]  = '{32'h81,  32'h0000AAAA, 2'b01, 1'b1, 32'hBEEF5566, 1'b1, 32'hBEEF5566};
    vecs[8]  = '{32'h82,  32'h00000000, 2'b10, 1'b1, 32'hBEEF5566, 1'b1, 32'hBEEF5566};
    vecs[9]  = '{32'h83,  32'h00001234, 2'b01, 1'b1, 32'hBEEF5566, 1'b1, 32'hBEEF5566};
    vecs[10] = '{32'h10,  32'hCAFEF00D, 2'b10, 1'b1, 32'h00000000, 1'b0, 32'hCAFEF00D};
    vecs[11] = '{32'h20,  32'h01020304, 2'b11, 1'b1, 32'h00000000, 1'b0, 32'h01020304};
    vecs[12] = '{32'h410, 32'h55555555, 2'b00, 1'b0, 32'hCAFEF00D, 1'b0, 32'hCAFEF00D};
    vecs[13] = '{32'h81,  32'h77777777, 2'b01, 1'b0, 32'hBEEF5566, 1'b0, 32'hBEEF5566};
    vecs[14] = '{32'h820, 32'hA5A5A5A5, 2'b10, 1'b1, 32'h01020304, 1'b0, 32'hA5A5A5A5};

    // Initial reset and sweep, with accesses attempted during busy.
    tick();
    check("busy_in_reset", 32'(bus.busy), 32'h1);
    check("sticky_reset", 32'(bus.err_sticky), 32'h0);
    rst = 1'b0;
    wait_ready(1000, 1'b1, n);
    check("sweep_len_first", 32'(n), 32'd256);
    check("busy_after_sweep", 32'(bus.busy), 32'h0);
    read_at(32'h30, "busy_write_ignored", 32'h0);

    // Preload a word, then confirm a reset pulse clears it.
    bus.addr = 32'h14; bus.wd = 32'hDEADBEEF; bus.storeCtrl = 2'b10; bus.memWrite = 1'b1;
    tick();
    read_at(32'h14, "preload", 32'hDEADBEEF);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("busy_after_pulse", 32'(bus.busy), 32'h1);
    wait_ready(1000, 1'b0, n);
    check("sweep_len_pulse", 32'(n), 32'd256);
    read_at(32'h14, "cleared_0x14", 32'h0);
    check("sticky_still_clear", 32'(bus.err_sticky), 32'h0);

    // Table-driven writes/reads.
    exp_sticky = 1'b0;
    foreach (vecs[i]) begin
      bus.addr = vecs[i].addr; bus.wd = vecs[i].wd;
      bus.storeCtrl = vecs[i].ctrl; bus.memWrite = vecs[i].we;
      #1;
      check($sformatf("v%0d_rd_pre", i), bus.rd, vecs[i].pre);
      check($sformatf("v%0d_mis", i), 32'(bus.misaligned), 32'(vecs[i].mis));
      tick();
      bus.memWrite = 1'b0;
      exp_sticky = exp_sticky | vecs[i].mis;
      #1;
      check($sformatf("v%0d_rd_post", i), bus.rd, vecs[i].post);
      check($sformatf("v%0d_sticky", i), 32'(bus.err_sticky), 32'(exp_sticky));
    end
    read_at(32'h40, "bytes_0x40", 32'hCD00AB00);
    read_at(32'h10, "rdw_0x10", 32'hCAFEF00D);
    read_at(32'h410, "alias_0x410", 32'hCAFEF00D);
    read_at(32'h20, "alias_write_0x20", 32'hA5A5A5A5);

    // Sticky holds across idle cycles.
    repeat (5) tick();
    check("sticky_holds", 32'(bus.err_sticky), 32'h1);

    // Reset mid-sweep restarts the full sweep.
    rst = 1'b1;
    tick();
    check("sticky_cleared_by_rst", 32'(bus.err_sticky), 32'h0);
    rst = 1'b0;
    wait_ready(100, 1'b0, n);
    check("partial_sweep", 32'(n), 32'd100);
    check("busy_mid_sweep", 32'(bus.busy), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_ready(1000, 1'b0, n);
    check("sweep_len_restart", 32'(n), 32'd256);
    read_at(32'h10, "cleared_0x10", 32'h0);
    read_at(32'h80, "cleared_0x80", 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
